// File: rtl/pipe_mem.sv
// rtl/pipe_mem.sv - MIPS MEM stage: EX/MEM register, req/ack data-memory access, MEM/WB register
module pipe_mem #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] wd,
    input  logic [4:0]  wa_e,
    input  logic [31:0] st_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        reg_wr,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_wa,
    output logic [31:0] wb_wd,
    output logic        fwd_we,
    output logic [4:0]  fwd_wa,
    output logic [31:0] fwd_wd,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [CW-1:0] cnt;

    // EX/MEM register fields
    logic        r_valid;
    logic [31:0] r_wd;
    logic [4:0]  r_wa;
    logic [31:0] r_st;
    logic        r_rd;
    logic        r_wr;
    logic        r_regwr;

    logic is_mem;
    logic aligned;
    logic complete;
    logic abort;
    logic misal_op;

    assign is_mem     = r_valid & (r_rd | r_wr);
    assign aligned    = (r_wd[1:0] == 2'b00);
    assign dmem_addr  = r_wd;
    assign dmem_wdata = r_st;
    assign dmem_we    = r_wr;

    // Loads are never forwarded from here; the hazard unit stalls load-use instead
    assign fwd_we = r_valid & r_regwr & ~r_rd & (r_wa != 5'd0);
    assign fwd_wa = r_wa;
    assign fwd_wd = r_wd;

    // Request/stall decode and next-state; ack takes priority over timeout
    always_comb begin
        dmem_req  = 1'b0;
        stall_out = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        misal_op  = 1'b0;
        state_nxt = state;
        case (state)
            RUN: begin
                if (is_mem && aligned) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                        state_nxt = WAIT;
                    end
                end else begin
                    complete = 1'b1;
                    misal_op = is_mem;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    complete  = 1'b1;
                    state_nxt = RUN;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    complete  = 1'b1;
                    abort     = 1'b1;
                    state_nxt = RUN;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM state and wait-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // EX/MEM register: advances whenever the stage is not stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_wd    <= '0;
            r_wa    <= '0;
            r_st    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_regwr <= 1'b0;
        end else if (!stall_out) begin
            r_valid <= in_valid;
            r_wd    <= wd;
            r_wa    <= wa_e;
            r_st    <= st_data;
            r_rd    <= mem_rd;
            r_wr    <= mem_wr;
            r_regwr <= reg_wr;
        end
    end

    // MEM/WB register: retires on completion, takes a bubble while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_wa    <= '0;
            wb_wd    <= '0;
        end else if (complete) begin
            wb_valid <= r_valid;
            wb_wa    <= r_wa;
            wb_wd    <= r_rd ? dmem_rdata : r_wd;
            wb_we    <= r_valid & r_regwr & (r_wa != 5'd0) & ~misal_op & ~abort;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end
    end

    // One-cycle error pulses for dropped misaligned ops and timed-out accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            misalign <= misal_op;
            bus_err  <= abort;
        end
    end

endmodule

// File: tb/tb_pipe_mem.sv
// tb/tb_pipe_mem.sv - scoreboard bench for the MEM pipeline stage
module tb_pipe_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] wd = '0;
    logic [4:0]  wa_e = '0;
    logic [31:0] st_data = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic        reg_wr = 1'b0;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        fwd_we;
    logic [4:0]  fwd_wa;
    logic [31:0] fwd_wd;
    logic        misalign;
    logic        bus_err;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wb_t;

    wb_t sb[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    pipe_mem #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wd(wd), .wa_e(wa_e),
        .st_data(st_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_wa(wb_wa),
        .wb_wd(wb_wd), .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_wd(fwd_wd),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Retirement monitor: every valid MEM/WB entry must match the oldest expectation
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got retire wa=%0d wd=%h, want none", wb_wa, wb_wd);
            end else begin
                wb_t e;
                e = sb.pop_front();
                if ({wb_we, wb_wa, wb_wd} !== e)
                    $display("FAIL sb_retire: got we=%b wa=%0d wd=%h, want we=%b wa=%0d wd=%h",
                             wb_we, wb_wa, wb_wd, e.we, e.wa, e.wd);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] d, input logic [4:0] a,
                           input logic [31:0] s, input logic rd, input logic wr, input logic rw);
        in_valid = v; wd = d; wa_e = a; st_data = s; mem_rd = rd; mem_wr = wr; reg_wr = rw;
    endtask

    task automatic idle();
        present(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if ({stall_out, dmem_req, fwd_we, wb_valid, wb_we, misalign, bus_err, wb_wa, wb_wd} !== '0)
            $display("FAIL reset_state: got stall=%b req=%b fwd_we=%b wbv=%b wbwe=%b mis=%b berr=%b wa=%0d wd=%h, want all 0",
                     stall_out, dmem_req, fwd_we, wb_valid, wb_we, misalign, bus_err, wb_wa, wb_wd);
        else pass_cnt++;
    endtask

    task automatic test_alu();
        present(1'b1, 32'h1234, 5'd5, 32'h0, 1'b0, 1'b0, 1'b1);
        sb.push_back('{1'b1, 5'd5, 32'h1234});
        tick();
        idle();
        total_cnt++;
        if ({fwd_we, fwd_wa, fwd_wd, dmem_req, stall_out} !== {1'b1, 5'd5, 32'h1234, 1'b0, 1'b0})
            $display("FAIL alu_fwd: got fwd_we=%b fwd_wa=%0d fwd_wd=%h req=%b stall=%b, want 1 5 1234 0 0",
                     fwd_we, fwd_wa, fwd_wd, dmem_req, stall_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid: got %b want 1", wb_valid);
        else pass_cnt++;
    endtask

    task automatic test_lw_wait();
        present(1'b1, 32'h100, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1);
        sb.push_back('{1'b1, 5'd7, 32'hDEADBEEF});
        tick();
        present(1'b1, 32'h55, 5'd8, 32'h0, 1'b0, 1'b0, 1'b1);
        sb.push_back('{1'b1, 5'd8, 32'h55});
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({stall_out, dmem_req, dmem_we, dmem_addr, fwd_we} !== {1'b1, 1'b1, 1'b0, 32'h100, 1'b0})
                $display("FAIL lw_wait_cycle%0d: got stall=%b req=%b we=%b addr=%h fwd_we=%b, want 1 1 0 100 0",
                         i, stall_out, dmem_req, dmem_we, dmem_addr, fwd_we);
            else pass_cnt++;
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if ({stall_out, dmem_req, dmem_addr} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL lw_ack_cycle: got stall=%b req=%b addr=%h, want 0 1 100", stall_out, dmem_req, dmem_addr);
        else pass_cnt++;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        idle();
        total_cnt++;
        if ({fwd_we, fwd_wa, fwd_wd, stall_out} !== {1'b1, 5'd8, 32'h55, 1'b0})
            $display("FAIL lw_next_entered: got fwd_we=%b fwd_wa=%0d fwd_wd=%h stall=%b, want 1 8 55 0",
                     fwd_we, fwd_wa, fwd_wd, stall_out);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_sw();
        present(1'b1, 32'h20, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
        sb.push_back('{1'b0, 5'd3, 32'h20});
        tick();
        idle();
        dmem_ack = 1'b1;
        #1;
        total_cnt++;
        if ({dmem_req, dmem_we, dmem_wdata, dmem_addr, stall_out} !== {1'b1, 1'b1, 32'hA5A5A5A5, 32'h20, 1'b0})
            $display("FAIL sw_req: got req=%b we=%b wdata=%h addr=%h stall=%b, want 1 1 a5a5a5a5 20 0",
                     dmem_req, dmem_we, dmem_wdata, dmem_addr, stall_out);
        else pass_cnt++;
        tick();
        dmem_ack = 1'b0;
        total_cnt++;
        if (dmem_req !== 1'b0) $display("FAIL sw_req_drop: got %b want 0", dmem_req);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_misalign();
        present(1'b1, 32'h102, 5'd9, 32'h0, 1'b1, 1'b0, 1'b1);
        sb.push_back('{1'b0, 5'd9, 32'h0});
        tick();
        idle();
        total_cnt++;
        if ({dmem_req, stall_out} !== 2'b00)
            $display("FAIL mis_noreq: got req=%b stall=%b, want 0 0", dmem_req, stall_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({misalign, wb_valid, wb_we} !== 3'b110)
            $display("FAIL mis_pulse: got mis=%b wbv=%b wbwe=%b, want 1 1 0", misalign, wb_valid, wb_we);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (misalign !== 1'b0) $display("FAIL mis_oneshot: got %b want 0", misalign);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n;
        present(1'b1, 32'h40, 5'd10, 32'h0, 1'b1, 1'b0, 1'b1);
        sb.push_back('{1'b0, 5'd10, 32'h0});
        tick();
        idle();
        n = 0;
        while (stall_out === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total_cnt++;
        if (n !== 16) $display("FAIL to_stall_len: got %0d cycles want 16", n);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus_err, dmem_req, stall_out, wb_we} !== 4'b1000)
            $display("FAIL to_abort: got berr=%b req=%b stall=%b wbwe=%b, want 1 0 0 0",
                     bus_err, dmem_req, stall_out, wb_we);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus_err, dmem_req} !== 2'b00) $display("FAIL to_oneshot: got berr=%b req=%b want 0 0", bus_err, dmem_req);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        present(1'b1, 32'h80, 5'd11, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick(); tick();
        total_cnt++;
        if ({dmem_req, stall_out} !== 2'b11) $display("FAIL rstmid_wait: got req=%b stall=%b want 1 1", dmem_req, stall_out);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({dmem_req, stall_out, wb_valid, wb_we, wb_wa, wb_wd, fwd_we, fwd_wa, fwd_wd} !== '0)
            $display("FAIL rstmid_clear: got req=%b stall=%b wbv=%b wbwe=%b wa=%0d wd=%h fwe=%b fwa=%0d fwd=%h, want all 0",
                     dmem_req, stall_out, wb_valid, wb_we, wb_wa, wb_wd, fwd_we, fwd_wa, fwd_wd);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_zero_reg();
        present(1'b1, 32'h77, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        sb.push_back('{1'b0, 5'd0, 32'h77});
        tick();
        idle();
        total_cnt++;
        if (fwd_we !== 1'b0) $display("FAIL zero_fwd: got %b want 0", fwd_we);
        else pass_cnt++;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE0000;
        for (int i = 1; i <= 3; i++) begin
            present(1'b1, 32'h1000 + 32'(i), 5'(i), 32'h0, 1'b0, 1'b0, 1'b1);
            sb.push_back('{1'b1, 5'(i), 32'h1000 + 32'(i)});
            tick();
        end
        present(1'b1, 32'h10, 5'd4, 32'h0, 1'b1, 1'b0, 1'b1);
        sb.push_back('{1'b1, 5'd4, 32'hCAFE0000});
        tick();
        idle();
        total_cnt++;
        if ({dmem_req, stall_out, dmem_addr} !== {1'b1, 1'b0, 32'h10})
            $display("FAIL b2b_lw: got req=%b stall=%b addr=%h want 1 0 10", dmem_req, stall_out, dmem_addr);
        else pass_cnt++;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_sw();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_zero_reg();
        test_back_to_back();
        total_cnt++;
        if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
